// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle 32-bit restoring divider for EX-stage DIV/DIVU.
// Captures operands on a level start request, iterates WIDTH shift-subtract
// steps on magnitudes, applies sign fixup and presents {remainder, quotient}
// with ready_o held until start_i drops. annul_i aborts at any point.
//
// state  | meaning
// -------+-----------------------------------------------------------
// FREE   | idle, waiting for start_i with annul_i low
// BYZERO | divisor was zero; result forced to 0
// ON     | running one restoring step per cycle
// END    | result published, held while start_i stays high
module div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BYZERO = 2'd1;
    localparam logic [1:0] ON     = 2'd2;
    localparam logic [1:0] END    = 2'd3;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic [CW-1:0]    cnt;
    logic             sgn_q;
    logic             neg_a;
    logic             neg_b;

    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    // Operand magnitudes, one restoring trial subtraction, and the sign fixup.
    // The most negative value maps onto itself, which is the correct magnitude
    // once read as unsigned.
    always_comb begin
        abs_a   = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
        abs_b   = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + 1'b1) : opdata2_i;
        trial   = {rem, quo[WIDTH-1]} - {1'b0, dvs};
        quo_fix = (sgn_q && (neg_a ^ neg_b)) ? (~quo + 1'b1) : quo;
        rem_fix = (sgn_q && neg_a) ? (~rem + 1'b1) : rem;
    end

    // Sequencer state, working registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FREE;
            quo      <= '0;
            dvs      <= '0;
            rem      <= '0;
            cnt      <= '0;
            sgn_q    <= 1'b0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            state <= BYZERO;
                        end else begin
                            quo   <= abs_a;
                            dvs   <= abs_b;
                            rem   <= '0;
                            cnt   <= '0;
                            sgn_q <= signed_div_i;
                            neg_a <= opdata1_i[WIDTH-1];
                            neg_b <= opdata2_i[WIDTH-1];
                            state <= ON;
                        end
                    end
                end
                BYZERO: begin
                    if (annul_i) begin
                        state <= FREE;
                    end else begin
                        // Clearing the magnitudes makes the END fixup yield zero.
                        quo   <= '0;
                        rem   <= '0;
                        sgn_q <= 1'b0;
                        state <= END;
                    end
                end
                ON: begin
                    if (annul_i) begin
                        state <= FREE;
                    end else begin
                        if (!trial[WIDTH]) begin
                            rem <= trial[WIDTH-1:0];
                            quo <= {quo[WIDTH-2:0], 1'b1};
                        end else begin
                            rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
                            quo <= {quo[WIDTH-2:0], 1'b0};
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            state <= END;
                        end
                    end
                end
                END: begin
                    if (annul_i) begin
                        state    <= FREE;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end else if (!ready_o) begin
                        // First END cycle publishes the fixed-up result.
                        result_o <= {rem_fix, quo_fix};
                        ready_o  <= 1'b1;
                    end else if (!start_i) begin
                        state    <= FREE;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end
                end
                default: begin
                    state    <= FREE;
                    ready_o  <= 1'b0;
                    result_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed boundary cases, annul and
// reset scenarios, and random divides compared against an arithmetic model.
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int errors = 0;
    int checks = 0;

    div_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic division, truncating toward zero.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb, q, r;
        logic [31:0] qq, rr;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q  = sa / sb;
        r  = sa % sb;
        qq = q[31:0];
        rr = r[31:0];
        return {rr, qq};
    endfunction

    // Full handshake: latency, result, hold while start high, release.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s, input string tag);
        int lat;
        logic [63:0] exp;
        exp = model(a, b, s);
        @(negedge clk);
        opdata1_i = a; opdata2_i = b; signed_div_i = s; start_i = 1'b1;
        @(posedge clk);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (ready_o) begin
                lat = n;
                break;
            end
            opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = 1'($urandom);
        end
        check({tag, " latency"}, 64'(lat), (b == 32'd0) ? 64'd2 : 64'd33);
        check({tag, " result"}, result_o, exp);
        @(posedge clk); #1;
        check({tag, " hold ready"}, 64'(ready_o), 64'd1);
        check({tag, " hold result"}, result_o, exp);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk); #1;
        check({tag, " drop ready"}, 64'(ready_o), 64'd0);
        check({tag, " drop result"}, result_o, 64'd0);
    endtask

    initial begin
        int seen;
        logic [31:0] ra, rb;
        logic rs;
        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset ready", 64'(ready_o), 64'd0);
        check("reset result", result_o, 64'd0);
        @(negedge clk); rst = 1'b0;

        do_div(32'd7, 32'd2, 1'b0, "u 7/2");
        do_div(32'hFFFF_FFF9, 32'd2, 1'b1, "s -7/2");
        do_div(32'd7, 32'hFFFF_FFFE, 1'b1, "s 7/-2");
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "s min/-1");
        do_div(32'hFFFF_FFFF, 32'd1, 1'b0, "u max/1");
        do_div(32'd5, 32'hFFFF_FFFF, 1'b0, "u 5/max");
        do_div(32'd123, 32'd0, 1'b0, "divzero");
        do_div(32'h8000_0000, 32'd0, 1'b1, "s divzero");
        check("const u 7/2", model(32'd7, 32'd2, 1'b0) ^ result_o, 64'h0000_0001_0000_0003);

        // Annul at iteration 10, EX drops start on the flush.
        @(negedge clk);
        opdata1_i = 32'd1000; opdata2_i = 32'd3; signed_div_i = 1'b0; start_i = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk); annul_i = 1'b1; start_i = 1'b0;
        @(posedge clk); #1;
        check("annul ready", 64'(ready_o), 64'd0);
        check("annul result", result_o, 64'd0);
        @(negedge clk); annul_i = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready_o) seen++;
        end
        check("annul no ready pulse", 64'(seen), 64'd0);
        do_div(32'd100, 32'd7, 1'b0, "post-annul 100/7");

        // Reset mid-operation at iteration 20.
        @(negedge clk);
        opdata1_i = 32'd12345; opdata2_i = 32'd17; start_i = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("midreset ready", 64'(ready_o), 64'd0);
        check("midreset result", result_o, 64'd0);
        @(negedge clk); rst = 1'b0; start_i = 1'b0;

        // Start held together with annul must never launch.
        @(negedge clk);
        start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd50; opdata2_i = 32'd5;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready_o) seen++;
        end
        check("start+annul no launch", 64'(seen), 64'd0);
        @(negedge clk); start_i = 1'b0; annul_i = 1'b0;
        do_div(32'hFFFF_FF00, 32'd9, 1'b1, "post-reset s");

        // Annul while the result is published.
        @(negedge clk);
        opdata1_i = 32'd99; opdata2_i = 32'd10; signed_div_i = 1'b0; start_i = 1'b1;
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (ready_o) begin
                seen = 1;
                break;
            end
        end
        check("end-annul reached ready", 64'(seen), 64'd1);
        check("end-annul result", result_o, 64'h0000_0009_0000_0009);
        @(negedge clk); annul_i = 1'b1;
        @(posedge clk); #1;
        check("end-annul ready", 64'(ready_o), 64'd0);
        @(negedge clk); annul_i = 1'b0; start_i = 1'b0;

        // Random divides, including small and zero divisors.
        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rs = 1'($urandom);
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 20));
                2: rb = -32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            do_div(ra, rb, rs, $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
